// File: rtl/rede_out_collector_if.sv
// Result bus between the rede core output mux, the collector FIFO and its consumer.
// master drives results in and accepts the head entry; slave is the collector.
interface rede_out_collector_if #(
  parameter int DATA_W = 31
);
  logic signed [DATA_W-1:0] in_data;
  logic [3:0]               in_en;
  logic [4:0]               in_core;
  logic signed [DATA_W-1:0] out_data;
  logic [3:0]               out_port;
  logic [4:0]               out_core;
  logic                     out_valid;
  logic                     out_ready;

  modport master (
    output in_data, in_en, in_core, out_ready,
    input  out_data, out_port, out_core, out_valid
  );

  modport slave (
    input  in_data, in_en, in_core, out_ready,
    output out_data, out_port, out_core, out_valid
  );
endinterface

// File: rtl/rede_out_collector.sv
// First-word-fall-through collector for rede core results, with drop accounting.
// Optional macro REDE_COLLECT_TIMESTAMP_EN adds a 16-bit cycle stamp per entry (out_ts).
module rede_out_collector #(
  parameter int DEPTH = 16,
  parameter int NCORE = 24,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic                clk,
  input  logic                rst,
  rede_out_collector_if.slave bus,
  input  logic                clr,
  output logic                full,
  output logic                empty,
  output logic [AW:0]         count,
  output logic                overflow,
  output logic [7:0]          drop_cnt
`ifdef REDE_COLLECT_TIMESTAMP_EN
  ,
  output logic [15:0]         out_ts
`endif
);

  localparam int DATA_W = 31;
  localparam logic [5:0]  NCORE_L = 6'(NCORE);
  localparam logic [AW:0] DEPTH_L = (AW+1)'(DEPTH);

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  logic signed [DATA_W-1:0] mem_data [DEPTH];
  logic [3:0]               mem_port [DEPTH];
  logic [4:0]               mem_core [DEPTH];
  logic [AW-1:0]            wr_ptr, rd_ptr;
  logic [AW:0]              count_nxt;
  logic                     push_req, pop, wr_en, drop;

  assign full  = (count == DEPTH_L);
  assign empty = (count == '0);

  // Accept/drop decision: a full FIFO still takes a push when the head leaves the same edge
  always_comb begin
    push_req = (bus.in_en != 4'd0) && ({1'b0, bus.in_core} < NCORE_L);
    pop      = !empty && bus.out_ready;
    wr_en    = push_req && (!full || pop);
    drop     = push_req && full && !pop;
    count_nxt = count;
    case ({wr_en, pop})
      2'b10:   count_nxt = count + 1'b1;
      2'b01:   count_nxt = count - 1'b1;
      default: count_nxt = count;
    endcase
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_data[wr_ptr] <= bus.in_data;
      mem_port[wr_ptr] <= bus.in_en;
      mem_core[wr_ptr] <= bus.in_core;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
      drop_cnt <= 8'd0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (pop)   rd_ptr <= rd_ptr + 1'b1;
      count <= count_nxt;
      // A drop on the clearing edge leaves a fresh count of one
      if (drop) begin
        overflow <= 1'b1;
        drop_cnt <= clr ? 8'd1 : sat_inc8(drop_cnt);
      end else if (clr) begin
        overflow <= 1'b0;
        drop_cnt <= 8'd0;
      end
    end
  end

  // Storage is not reset, so the head is gated to zero whenever nothing is held
  assign bus.out_valid = !empty;
  assign bus.out_data  = empty ? '0 : mem_data[rd_ptr];
  assign bus.out_port  = empty ? '0 : mem_port[rd_ptr];
  assign bus.out_core  = empty ? '0 : mem_core[rd_ptr];

`ifdef REDE_COLLECT_TIMESTAMP_EN
  logic [15:0] ts_cnt;
  logic [15:0] mem_ts [DEPTH];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) ts_cnt <= 16'd0;
    else     ts_cnt <= ts_cnt + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem_ts[wr_ptr] <= ts_cnt;
  end

  assign out_ts = empty ? 16'd0 : mem_ts[rd_ptr];
`endif

endmodule

// File: tb/tb_rede_out_collector.sv
// Bench for rede_out_collector: fixed vector table, corner sequences and a
// randomized run checked against a queue-based reference model.
module tb_rede_out_collector;

  localparam int DEPTH = 16;
  localparam int NCORE = 24;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       clr = 1'b0;
  logic       full, empty, overflow;
  logic [4:0] count;
  logic [7:0] drop_cnt;
`ifdef REDE_COLLECT_TIMESTAMP_EN
  logic [15:0] out_ts;
`endif

  rede_out_collector_if bus ();

  rede_out_collector #(.DEPTH(DEPTH), .NCORE(NCORE)) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus),
    .clr      (clr),
    .full     (full),
    .empty    (empty),
    .count    (count),
    .overflow (overflow),
    .drop_cnt (drop_cnt)
`ifdef REDE_COLLECT_TIMESTAMP_EN
    ,
    .out_ts   (out_ts)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    int data;
    int port;
    int core;
    int ts;
  } ent_t;

  ent_t q[$];
  int   m_ovf;
  int   m_drop;
  int   m_ts;
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic check(input string nm, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
    end
  endtask

  task automatic m_reset();
    q.delete();
    m_ovf  = 0;
    m_drop = 0;
    m_ts   = 0;
  endtask

  // Reference behaviour on one rising edge, from the collector's rules
  task automatic model_step(input int d, input int en, input int core, input bit rdy, input bit c);
    int   sz;
    bit   pop, push, dropped;
    ent_t e;
    logic signed [30:0] t;
    t = 31'(d);
    sz = q.size();
    pop = (sz > 0) && rdy;
    push = (en != 0) && (core < NCORE);
    dropped = 0;
    e.data = int'(t);
    e.port = en;
    e.core = core;
    e.ts   = m_ts;
    if (pop) void'(q.pop_front());
    if (push) begin
      if (sz < DEPTH || pop) q.push_back(e);
      else dropped = 1;
    end
    if (dropped) begin
      m_ovf  = 1;
      m_drop = c ? 1 : ((m_drop < 255) ? m_drop + 1 : 255);
    end else if (c) begin
      m_ovf  = 0;
      m_drop = 0;
    end
    m_ts = (m_ts + 1) % 65536;
  endtask

  task automatic compare_model();
    check("count", int'(count), q.size());
    check("out_valid", int'(bus.out_valid), (q.size() > 0) ? 1 : 0);
    check("full", int'(full), (q.size() == DEPTH) ? 1 : 0);
    check("empty", int'(empty), (q.size() == 0) ? 1 : 0);
    check("overflow", int'(overflow), m_ovf);
    check("drop_cnt", int'(drop_cnt), m_drop);
    if (q.size() > 0) begin
      check("head_data", int'(bus.out_data), q[0].data);
      check("head_port", int'(bus.out_port), q[0].port);
      check("head_core", int'(bus.out_core), q[0].core);
`ifdef REDE_COLLECT_TIMESTAMP_EN
      check("head_ts", int'(out_ts), q[0].ts);
`endif
    end
  endtask

  task automatic apply(input int d, input int en, input int core, input bit rdy, input bit c);
    bus.in_data   = 31'(d);
    bus.in_en     = 4'(en);
    bus.in_core   = 5'(core);
    bus.out_ready = rdy;
    clr           = c;
    @(posedge clk);
    model_step(d, en, core, rdy, c);
    #1;
    compare_model();
  endtask

  task automatic idle_inputs();
    bus.in_data   = '0;
    bus.in_en     = 4'd0;
    bus.in_core   = 5'd0;
    bus.out_ready = 1'b0;
    clr           = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    m_reset();
  endtask

  typedef struct {
    int data; int en; int core; bit rdy; bit c;
    int e_cnt; int e_vld; int e_data; int e_port; int e_core;
  } vec_t;

  vec_t vecs[8];

  initial begin
    vecs[0] = '{-5,          1,  3, 1'b0, 1'b0, 1, 1, -5,          1,  3};
    vecs[1] = '{7,           2, 24, 1'b0, 1'b0, 1, 1, -5,          1,  3};
    vecs[2] = '{0,           0,  5, 1'b0, 1'b0, 1, 1, -5,          1,  3};
    vecs[3] = '{9,           3,  0, 1'b1, 1'b0, 1, 1, 9,           3,  0};
    vecs[4] = '{0,           0,  0, 1'b1, 1'b0, 0, 0, 0,           0,  0};
    vecs[5] = '{100,        15, 23, 1'b1, 1'b0, 1, 1, 100,        15, 23};
    vecs[6] = '{55,          4, 31, 1'b1, 1'b0, 0, 0, 0,           0,  0};
    vecs[7] = '{-1073741824, 8,  1, 1'b0, 1'b0, 1, 1, -1073741824, 8,  1};

    idle_inputs();
    m_reset();
    #2;
    check("rst_count", int'(count), 0);
    check("rst_empty", int'(empty), 1);
    check("rst_full", int'(full), 0);
    check("rst_valid", int'(bus.out_valid), 0);
    check("rst_data", int'(bus.out_data), 0);
    do_reset();

    for (int i = 0; i < 8; i++) begin
      apply(vecs[i].data, vecs[i].en, vecs[i].core, vecs[i].rdy, vecs[i].c);
      check($sformatf("vec%0d_count", i), int'(count), vecs[i].e_cnt);
      check($sformatf("vec%0d_valid", i), int'(bus.out_valid), vecs[i].e_vld);
      check($sformatf("vec%0d_data", i), int'(bus.out_data), vecs[i].e_data);
      check($sformatf("vec%0d_port", i), int'(bus.out_port), vecs[i].e_port);
      check($sformatf("vec%0d_core", i), int'(bus.out_core), vecs[i].e_core);
      check($sformatf("vec%0d_ovf", i), int'(overflow), 0);
    end

    // Fill past capacity with the consumer stalled
    do_reset();
    for (int i = 0; i < 17; i++) apply(1000 + i, 1 + (i % 15), i % 24, 1'b0, 1'b0);
    check("fill_full", int'(full), 1);
    check("fill_count", int'(count), 16);
    check("fill_ovf", int'(overflow), 1);
    check("fill_drop", int'(drop_cnt), 1);
    check("fill_head", int'(bus.out_data), 1000);

    // Push and pop together while full
    apply(2000, 5, 7, 1'b1, 1'b0);
    check("fullpp_count", int'(count), 16);
    check("fullpp_drop", int'(drop_cnt), 1);
    check("fullpp_head", int'(bus.out_data), 1001);
    for (int i = 0; i < 15; i++) apply(0, 0, 0, 1'b1, 1'b0);
    check("fullpp_last", int'(bus.out_data), 2000);
    check("fullpp_last_cnt", int'(count), 1);
    apply(0, 0, 0, 1'b1, 1'b0);
    check("drained", int'(empty), 1);

    // Saturating drop counter and clear
    do_reset();
    for (int i = 0; i < 16 + 300; i++) apply(i, 1, 2, 1'b0, 1'b0);
    check("sat_drop", int'(drop_cnt), 255);
    check("sat_ovf", int'(overflow), 1);
    apply(0, 0, 0, 1'b0, 1'b1);
    check("clr_drop", int'(drop_cnt), 0);
    check("clr_ovf", int'(overflow), 0);
    apply(42, 3, 4, 1'b0, 1'b1);
    check("clrdrop_drop", int'(drop_cnt), 1);
    check("clrdrop_ovf", int'(overflow), 1);

    // Asynchronous reset while full
    #3;
    rst = 1'b1;
    #1;
    check("async_count", int'(count), 0);
    check("async_empty", int'(empty), 1);
    check("async_valid", int'(bus.out_valid), 0);
    check("async_data", int'(bus.out_data), 0);
    check("async_drop", int'(drop_cnt), 0);
    check("async_ovf", int'(overflow), 0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    m_reset();
    apply(77, 6, 9, 1'b0, 1'b0);
    check("post_rst_head", int'(bus.out_data), 77);
    check("post_rst_count", int'(count), 1);

`ifdef REDE_COLLECT_TIMESTAMP_EN
    do_reset();
    repeat (10) apply(0, 0, 0, 1'b0, 1'b0);
    apply(10, 1, 1, 1'b0, 1'b0);
    apply(0, 0, 0, 1'b0, 1'b0);
    apply(12, 1, 2, 1'b0, 1'b0);
    check("ts_first", int'(out_ts), 10);
    apply(0, 0, 0, 1'b1, 1'b0);
    check("ts_second", int'(out_ts), 12);
`endif

    // Randomized traffic against the reference model
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      int en;
      en = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(1, 15));
      apply(int'($urandom), en, int'($urandom_range(0, 27)),
            ($urandom_range(0, 9) < 4), ($urandom_range(0, 49) == 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/rede_out_collector.md
REDE_OUT_COLLECTOR -- requirements
Module: rede_out_collector

Interface
REQ-001 Parameter DEPTH, default 16, FIFO entries; power of two, 4..64.
REQ-002 Parameter NCORE, default 24, number of rede cores feeding the collector.
REQ-003 Port clk, input, 1, single clock; all logic on its rising edge.
REQ-004 Port rst, input, 1, asynchronous, active-high reset.
REQ-005 Port in_data, input, 31 signed, result word from the core output mux.
REQ-006 Port in_en, input, 4, output-port id from the selected core; 0 = no result this cycle.
REQ-007 Port in_core, input, 5, index of the core driving in_data/in_en.
REQ-008 Port clr, input, 1, synchronous clear of the overflow and drop_cnt status.
REQ-009 Port out_data, output, 31 signed, head-entry data.
REQ-010 Port out_port, output, 4, head-entry port id.
REQ-011 Port out_core, output, 5, head-entry core index.
REQ-012 Port out_valid, output, 1, head entry present.
REQ-013 Port out_ready, input, 1, consumer accepts the head entry.
REQ-014 Port full, output, 1, occupancy == DEPTH.
REQ-015 Port empty, output, 1, occupancy == 0.
REQ-016 Port count, output, log2(DEPTH)+1, current occupancy.
REQ-017 Port overflow, output, 1, sticky flag set when a result is dropped.
REQ-018 Port drop_cnt, output, 8, saturating count of dropped results.

Function
REQ-019 Push condition: in_en != 0 and in_core < NCORE; the entry {in_data, in_en, in_core} is written on that edge.
REQ-020 in_en != 0 with in_core >= NCORE shall be discarded, and shall not count as an overflow.
REQ-021 The FIFO shall be first-word-fall-through: out_valid = !empty, and out_* present the oldest entry combinationally from storage.
REQ-022 Pop occurs on an edge with out_valid && out_ready; popping while empty has no effect.
REQ-023 Push while full without a pop: entry dropped, overflow set to 1, drop_cnt incremented.
REQ-024 drop_cnt saturates at 255.
REQ-025 Push while full with a simultaneous pop shall be accepted; count stays DEPTH and nothing is dropped.
REQ-026 Push and pop in the same cycle at any other occupancy: count unchanged, order preserved.
REQ-027 Read and write pointers wrap modulo DEPTH; count is tracked separately to disambiguate full from empty.
REQ-028 Latency: a pushed entry appears on out_* with out_valid=1 on the cycle after the push edge when the FIFO was empty.
REQ-029 clr clears overflow and drop_cnt next edge; if clr coincides with a drop, the drop wins (overflow=1, drop_cnt=1).
REQ-030 out_data, out_port and out_core shall be held stable while out_valid=1 and out_ready=0.

Reset
REQ-031 rst=1 shall asynchronously clear pointers, count, overflow and drop_cnt; empty=1, full=0, out_valid=0.
REQ-032 out_data, out_port and out_core shall read 0 during reset (storage cleared or output gated).
REQ-033 Reset mid-operation shall discard all entries; the first push after deassertion is the new head.

Configuration
REQ-034 Macro REDE_COLLECT_TIMESTAMP_EN defined: a 16-bit free-running cycle counter, reset to 0 and wrapping at 65535, is stored with each entry and presented on an extra output port out_ts[15:0].
REQ-035 Macro undefined: no counter and no out_ts port; all other behaviour is identical.

Verification
REQ-036 Reset, then push in_data=-5, in_en=1, in_core=3 once -> next cycle out_valid=1, out_data=-5, out_port=1, out_core=3, count=1.
REQ-037 out_ready=0, 17 consecutive pushes at DEPTH=16 -> full=1, count=16, overflow=1, drop_cnt=1; head is the first push.
REQ-038 Full FIFO, push and pop in the same cycle -> count=16, drop_cnt unchanged, new entry is last out.
REQ-039 Push with in_core=24 -> count unchanged, overflow=0.
REQ-040 300 drops then clr=1 -> drop_cnt=255 before clr, 0 after; overflow=0.
REQ-041 With REDE_COLLECT_TIMESTAMP_EN, pushes at counter values 10 and 12 -> out_ts reads 10 then 12 on successive pops.
